imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
//
// PURPOSE
//   Shares the single-port instruction memory (imem: sync read, 1-cycle latency, word-indexed by a[31:2])
//   between the CPU fetch unit (read-only) and the debug/loader port (read/write).
//   At most one access is issued per cycle; the response returns on the following cycle.
//   After reset release, the memory interface is held quiet for a fixed window so imem preload completes.
//
// PARAMETERS
//   MEM_WORDS     64   imem depth in 32-bit words; debug/fetch word index >= MEM_WORDS -> error
//   STARVE_LIMIT  4    consecutive lost cycles after which fetch beats debug (1..15)
//   INIT_CYCLES   2    RESET_HOLD length after sys_rst_n deasserts (>=1)
//
// PORTS
//   clk         in   1   system clock, all state on posedge
//   sys_rst_n   in   1   asynchronous active-low reset
//   f_req       in   1   fetch request; f_addr stable until f_gnt
//   f_addr      in   32  fetch byte address
//   f_gnt       out  1   fetch accepted this cycle (combinational)
//   f_rvalid    out  1   fetch data valid (cycle after f_gnt)
//   f_rdata     out  32  fetch data; 0 when !f_rvalid or f_err
//   f_err       out  1   fetch misaligned / out-of-range (cycle after f_gnt)
//   d_req       in   1   debug request; d_we/d_addr/d_wdata stable until d_gnt
//   d_we        in   1   1 = write, 0 = read
//   d_addr      in   32  debug byte address
//   d_wdata     in   32  debug write data
//   d_gnt       out  1   debug accepted this cycle (combinational)
//   d_rvalid    out  1   debug read data valid (cycle after d_gnt)
//   d_wack      out  1   debug write done (cycle after d_gnt)
//   d_rdata     out  32  debug read data; 0 when !d_rvalid
//   d_err       out  1   debug misaligned / out-of-range (cycle after d_gnt)
//   mem_we      out  1   imem write enable
//   mem_a       out  32  imem byte address
//   mem_wdata   out  32  imem write data
//   mem_rd      in   32  imem registered read data
//
// BEHAVIOUR
//   - Reset (async): all outputs 0; state=RESET_HOLD; hold counter=0; owner_q=NONE; starve counter=0.
//     Reset mid-access discards the in-flight response (no rvalid/wack/err is issued).
//   - FSM RESET_HOLD: gnts=0; mem_we=0; mem_a=0; counts INIT_CYCLES clocks, then enters RUN.
//     FSM RUN: arbitrates every cycle and never leaves except on reset.
//   - Arbitration (RUN only):
//     - Only one requester: grant it.
//     - Both requesting: fetch wins iff starve_cnt >= STARVE_LIMIT; otherwise debug wins.
//   - starve_cnt: increments when f_req && !f_gnt in RUN; saturates at STARVE_LIMIT; clears on f_gnt.
//   - Issue (same cycle as gnt):
//     - mem_a = granted address; mem_wdata = d_wdata.
//     - mem_we = d_gnt && d_we && !err.
//     - No gnt: mem_we=0; mem_a=0; mem_wdata=0.
//   - Error checks:
//     - Error when addr[1:0] != 0 or addr[31:2] >= MEM_WORDS.
//     - An erroring request is still granted (it consumes the slot), but mem_we=0 and mem_a=0.
//   - Response pipe: owner_q is registered at the gnt edge, one of {NONE, F_RD, F_ERR, D_RD, D_WR, D_ERR}.
//     Next cycle it drives exactly one pulse:
//     - F_RD: f_rvalid with f_rdata = mem_rd.
//     - D_RD: d_rvalid with d_rdata = mem_rd.
//     - D_WR: d_wack.
//     - F_ERR / D_ERR: f_err / d_err.
//   - Throughput: back-to-back grants every cycle. Latency is gnt -> response = 1 cycle.
//   - A debug write followed by a read of the same word returns the new data.
//   - A request that drops before gnt is ignored (no response).
//
// STRUCTURE
//   - Shared header imem_arb_defs.vh:
//     - owner codes NONE/F_RD/F_ERR/D_RD/D_WR/D_ERR (3 b)
//     - state codes RESET_HOLD/RUN (1 b)
//     - IMEM_WORDS=64
//   - One sub-module: imem_arb_starve_ctr (saturating counter: inc, clr, limit -> starved flag).
//   - Everything else is flat: FSM, hold counter, arbitration/issue logic, owner_q pipe register.
//
// TESTING (drive against the real imem model)
//   1. Reset, 1 cycle later f_req @0x00 -> no gnt during RESET_HOLD.
//      Then f_gnt; next cycle f_rvalid=1, f_rdata=0x00000293.
//   2. f_req held, f_addr stepping 0x00..0x28 -> f_gnt every cycle.
//      f_rdata sequence 00000293,00000313,...,fd9ff06f with no bubbles.
//   3. d_req write 0x34 <- 0xA5A5A5A5, then read 0x34 -> d_wack, then d_rvalid with d_rdata=0xA5A5A5A5.
//   4. f_req and d_req held continuously (STARVE_LIMIT=4) -> pattern D,D,D,D,F repeating.
//      Fetch is never starved for more than 4 cycles.
//   5. d_addr=0x102 (misaligned) and d_addr=0x100 (word 64) -> d_err pulses; mem_we stays 0; RAM unchanged.
//      f_addr=0x101 -> f_err.
//   6. Assert sys_rst_n=0 in the cycle after a d_gnt for a write -> no d_wack.
//      All outputs 0 immediately; RESET_HOLD re-entered on release.

Source files
------------

// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the imem fetch/debug port arbiter: owner codes,
// FSM state codes, default memory depth and the address legality check.
package imem_port_arbiter_pkg;

    localparam int unsigned IMEM_WORDS = 64;

    localparam logic [2:0] OWN_NONE  = 3'd0;
    localparam logic [2:0] OWN_F_RD  = 3'd1;
    localparam logic [2:0] OWN_F_ERR = 3'd2;
    localparam logic [2:0] OWN_D_RD  = 3'd3;
    localparam logic [2:0] OWN_D_WR  = 3'd4;
    localparam logic [2:0] OWN_D_ERR = 3'd5;

    localparam logic ST_RESET_HOLD = 1'b0;
    localparam logic ST_RUN        = 1'b1;

    // Misaligned or beyond the last word of the memory.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= words);
    endfunction

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port lost arbitration;
// raises starved once the count reaches LIMIT.
module imem_arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic starved
);

    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt < LIM)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign starved = (cnt >= LIM);

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port imem between the fetch unit and the debug/loader
// port, one access per cycle, with a one-cycle response pipe.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = IMEM_WORDS,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned INIT_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_wack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rd
);

    localparam int unsigned HOLD_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(INIT_CYCLES - 1);

    logic              state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0]        owner_q;
    logic [2:0]        owner_next;
    logic              run;
    logic              starved;
    logic              f_bad;
    logic              d_bad;

    assign run   = (state == ST_RUN);
    assign f_bad = addr_bad(f_addr, MEM_WORDS);
    assign d_bad = addr_bad(d_addr, MEM_WORDS);

    imem_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (sys_rst_n),
        .inc     (run && f_req && !f_gnt),
        .clr     (f_gnt),
        .starved (starved)
    );

    // Debug has priority unless fetch has been starved long enough.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (run) begin
            if (f_req && (!d_req || starved)) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_a     = f_bad ? '0 : f_addr;
            mem_wdata = d_wdata;
        end else if (d_gnt) begin
            mem_a     = d_bad ? '0 : d_addr;
            mem_we    = d_we && !d_bad;
            mem_wdata = d_wdata;
        end
    end

    always_comb begin
        owner_next = OWN_NONE;
        if (f_gnt) begin
            owner_next = f_bad ? OWN_F_ERR : OWN_F_RD;
        end else if (d_gnt) begin
            owner_next = d_bad ? OWN_D_ERR : (d_we ? OWN_D_WR : OWN_D_RD);
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_RESET_HOLD;
            hold_cnt <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            owner_q <= owner_next;
            if (state == ST_RESET_HOLD) begin
                if (hold_cnt == HOLD_LAST) begin
                    state <= ST_RUN;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    assign f_rvalid = (owner_q == OWN_F_RD);
    assign f_rdata  = f_rvalid ? mem_rd : '0;
    assign f_err    = (owner_q == OWN_F_ERR);
    assign d_rvalid = (owner_q == OWN_D_RD);
    assign d_rdata  = d_rvalid ? mem_rd : '0;
    assign d_wack   = (owner_q == OWN_D_WR);
    assign d_err    = (owner_q == OWN_D_ERR);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter against a behavioural imem and a
// transaction-level reference model checked every cycle.
module tb_imem_port_arbiter;

    localparam int unsigned MEM_WORDS    = 64;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned INIT_CYCLES  = 2;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic        d_wack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rd = '0;

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .MEM_WORDS    (MEM_WORDS),
        .STARVE_LIMIT (STARVE_LIMIT),
        .INIT_CYCLES  (INIT_CYCLES)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_wack    (d_wack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Boot program: a small loop ending in a jump back to 0.
    function automatic logic [31:0] prog(input int unsigned w);
        case (w)
            0:       return 32'h00000293;
            1:       return 32'h00000313;
            2:       return 32'h00a00393;
            3:       return 32'h00128293;
            4:       return 32'h00530333;
            5:       return 32'hfff38393;
            6:       return 32'hfe039ce3;
            7:       return 32'h00602023;
            8:       return 32'h00002e03;
            9:       return 32'h00100073;
            10:      return 32'hfd9ff06f;
            default: return 32'h10000000 | w;
        endcase
    endfunction

    // Behavioural imem: synchronous read, one-cycle latency.
    logic [31:0] imem [0:63];
    always @(posedge clk) begin
        if (mem_we) imem[mem_a[7:2]] <= mem_wdata;
        mem_rd <= imem[mem_a[7:2]];
    end

    // Reference model state.
    logic [31:0] ref_mem [0:63];
    int unsigned m_cyc  = 0;
    int unsigned m_lost = 0;
    bit          p_frv, p_ferr, p_drv, p_dwack, p_derr;
    logic [31:0] p_data = '0;
    bit          e_fg, e_dg;

    function automatic bit bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(MEM_WORDS));
    endfunction

    always @(negedge clk) begin : compare
        bit          running;
        logic [31:0] ea;
        running = sys_rst_n && (m_cyc >= INIT_CYCLES);
        e_fg = running && f_req && (!d_req || (m_lost >= STARVE_LIMIT));
        e_dg = running && d_req && !e_fg;
        ea = e_fg ? (bad(f_addr) ? 32'h0 : f_addr)
           : e_dg ? (bad(d_addr) ? 32'h0 : d_addr) : 32'h0;
        chk("f_gnt",     32'(f_gnt),    32'(e_fg));
        chk("d_gnt",     32'(d_gnt),    32'(e_dg));
        chk("mem_we",    32'(mem_we),   32'(e_dg && d_we && !bad(d_addr)));
        chk("mem_a",     mem_a,         ea);
        chk("mem_wdata", mem_wdata,     (e_fg || e_dg) ? d_wdata : 32'h0);
        chk("f_rvalid",  32'(f_rvalid), 32'(p_frv));
        chk("f_rdata",   f_rdata,       p_frv ? p_data : 32'h0);
        chk("f_err",     32'(f_err),    32'(p_ferr));
        chk("d_rvalid",  32'(d_rvalid), 32'(p_drv));
        chk("d_rdata",   d_rdata,       p_drv ? p_data : 32'h0);
        chk("d_wack",    32'(d_wack),   32'(p_dwack));
        chk("d_err",     32'(d_err),    32'(p_derr));
    end

    always @(posedge clk or negedge sys_rst_n) begin : model
        bit running;
        if (!sys_rst_n) begin
            m_cyc  = 0;
            m_lost = 0;
            {p_frv, p_ferr, p_drv, p_dwack, p_derr} = '0;
            p_data = '0;
        end else begin
            running = (m_cyc >= INIT_CYCLES);
            {p_frv, p_ferr, p_drv, p_dwack, p_derr} = '0;
            p_data = '0;
            if (e_fg) begin
                m_lost = 0;
                if (bad(f_addr)) p_ferr = 1'b1;
                else begin
                    p_frv  = 1'b1;
                    p_data = ref_mem[f_addr[7:2]];
                end
            end else if (running && f_req) begin
                m_lost++;
            end
            if (e_dg) begin
                if (bad(d_addr)) p_derr = 1'b1;
                else if (d_we) begin
                    p_dwack = 1'b1;
                    ref_mem[d_addr[7:2]] = d_wdata;
                end else begin
                    p_drv  = 1'b1;
                    p_data = ref_mem[d_addr[7:2]];
                end
            end
            if (m_cyc < 1000) m_cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a grant on the selected port; leaves time at that negedge.
    task automatic wait_gnt(input bit dbg, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waited++;
            if (dbg ? d_gnt : f_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        chk(dbg ? "d_gnt_timeout" : "f_gnt_timeout", 32'(ok), 32'h1);
    endtask

    task automatic d_xact(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit rv, output bit wack, output bit err);
        bit ok;
        int w;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        wait_gnt(1'b1, ok, w);
        tick();
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        @(negedge clk);
        rd = d_rdata; rv = d_rvalid; wack = d_wack; err = d_err;
        tick();
    endtask

    task automatic f_xact(input logic [31:0] a, output logic [31:0] rd, output bit rv, output bit err);
        bit ok;
        int w;
        f_req = 1'b1; f_addr = a;
        wait_gnt(1'b0, ok, w);
        tick();
        f_req = 1'b0; f_addr = '0;
        @(negedge clk);
        rd = f_rdata; rv = f_rvalid; err = f_err;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          rv, wack, err, ok;
        int          w, lost_run, max_run;
        string       pat;

        for (int unsigned i = 0; i < 64; i++) begin
            imem[i]    = prog(i);
            ref_mem[i] = prog(i);
        end
        sys_rst_n = 1'b0;
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_f_gnt",  32'(f_gnt),  32'h0);
        chk("rst_mem_a",  mem_a,       32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_d_wack", 32'(d_wack), 32'h0);

        // 1: first fetch waits out the hold window.
        sys_rst_n = 1'b1;
        tick();
        f_req = 1'b1; f_addr = 32'h0;
        @(negedge clk);
        chk("hold_no_gnt", 32'(f_gnt), 32'h0);
        wait_gnt(1'b0, ok, w);
        chk("first_gnt_wait", 32'(w), 32'h1);
        tick();
        f_req = 1'b0;
        @(negedge clk);
        chk("first_rvalid", 32'(f_rvalid), 32'h1);
        chk("first_rdata",  f_rdata,       32'h00000293);
        tick();

        // 2: back-to-back fetch stream.
        f_req = 1'b1;
        for (int unsigned i = 0; i <= 10; i++) begin
            f_addr = i * 4;
            @(negedge clk);
            chk("stream_gnt", 32'(f_gnt), 32'h1);
            if (i > 0) begin
                chk("stream_rvalid", 32'(f_rvalid), 32'h1);
                chk("stream_rdata",  f_rdata,       prog(i - 1));
            end
            tick();
        end
        f_req = 1'b0; f_addr = '0;
        @(negedge clk);
        chk("stream_last", f_rdata, 32'hfd9ff06f);
        tick();

        // 3: write then read back.
        d_xact(1'b1, 32'h34, 32'hA5A5A5A5, rd, rv, wack, err);
        chk("wr_wack",   32'(wack), 32'h1);
        chk("wr_rvalid", 32'(rv),   32'h0);
        d_xact(1'b0, 32'h34, 32'h0, rd, rv, wack, err);
        chk("rd_rvalid", 32'(rv), 32'h1);
        chk("rd_data",   rd,      32'hA5A5A5A5);

        // 4: both ports contending.
        f_req = 1'b1; f_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        pat = "";
        lost_run = 0;
        max_run = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            pat = {pat, f_gnt ? "F" : (d_gnt ? "D" : "-")};
            lost_run = f_gnt ? 0 : lost_run + 1;
            if (lost_run > max_run) max_run = lost_run;
            tick();
        end
        f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
        checks++;
        if (pat != "DDDDFDDDDFDDDDF") begin
            errors++;
            $display("FAIL arb_pattern actual=%s required=DDDDFDDDDFDDDDF", pat);
        end
        chk("max_fetch_wait", 32'(max_run), 32'h4);
        tick();

        // 5: illegal addresses.
        d_xact(1'b1, 32'h102, 32'h11111111, rd, rv, wack, err);
        chk("misalign_derr", 32'(err),  32'h1);
        chk("misalign_wack", 32'(wack), 32'h0);
        d_xact(1'b1, 32'h100, 32'h22222222, rd, rv, wack, err);
        chk("range_derr", 32'(err), 32'h1);
        d_xact(1'b1, 32'h36, 32'hDEADBEEF, rd, rv, wack, err);
        chk("misalign_in_range_derr", 32'(err), 32'h1);
        chk("ram_unchanged", imem[13], 32'hA5A5A5A5);
        chk("ram_word0_unchanged", imem[0], 32'h00000293);
        f_xact(32'h101, rd, rv, err);
        chk("f_misalign_err",    32'(err), 32'h1);
        chk("f_misalign_rvalid", 32'(rv),  32'h0);
        chk("f_misalign_rdata",  rd,       32'h0);

        // 6: reset lands while a write response is pending.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h38; d_wdata = 32'h12345678;
        wait_gnt(1'b1, ok, w);
        tick();
        f_req = 1'b1; f_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_wack",   32'(d_wack),   32'h0);
        chk("rst_mid_f_gnt",  32'(f_gnt),    32'h0);
        chk("rst_mid_mem_a",  mem_a,         32'h0);
        chk("rst_mid_rvalid", 32'(d_rvalid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        @(negedge clk);
        chk("rehold_gnt0", 32'(f_gnt), 32'h0);
        tick();
        @(negedge clk);
        chk("rehold_gnt1", 32'(f_gnt), 32'h0);
        tick();
        @(negedge clk);
        chk("rerun_gnt", 32'(f_gnt), 32'h1);
        tick();
        f_req = 1'b0;
        @(negedge clk);
        chk("rerun_rdata", f_rdata, 32'h00000293);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
